motion_seq: RTL and testbench

Motion sequencer between the key debouncer and the PWM motor driver.
- On a debounced start pulse it runs one shuttle cycle: outbound leg (right) with soft-start, stop at the right limit or on catcher detect, dead time, return leg (left) to the left limit.
- Drives enable/direct/duty to the PWM block.
- Enforces per-leg timeout and limit-switch sanity checks, with a latched fault state.

---
 rtl/motion_pkg.sv | 23 ++
 rtl/in_sync.sv | 23 ++
 rtl/motion_seq.sv | 191 +++++++++++++++++++
 tb/tb_motion_seq.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/motion_pkg.sv
// rtl/motion_pkg.sv - shared state, leg and width definitions for the motion sequencer
package motion_pkg;

  localparam int DUTY_W = 3;

  localparam logic OUT = 1'b1;
  localparam logic RET = 1'b0;

  typedef enum logic [2:0] {
    IDLE,
    RAMP_UP,
    RUN,
    RAMP_DOWN,
    DEAD,
    FAULT
  } state_t;

  // States in which the motor is powered.
  function automatic logic is_moving(input state_t s);
    return (s == RAMP_UP) || (s == RUN) || (s == RAMP_DOWN);
  endfunction

endpackage

// File: rtl/in_sync.sv
// rtl/in_sync.sv - parameterised-width two-flop synchronizer, async active-low reset
module in_sync #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/motion_seq.sv
// rtl/motion_seq.sv - shuttle motion sequencer: soft-start legs, dead time, limit/timeout faults
module motion_seq
  import motion_pkg::*;
#(
  parameter int RAMP_STEP_CYC = 50000,
  parameter int DEAD_CYC      = 500000,
  parameter int TIMEOUT_CYC   = 250000000,
  parameter int DUTY_MAX      = 7
) (
  input  logic              sclk,
  input  logic              s_rst_n,
  input  logic              start,
  input  logic              catcher,
  input  logic              jockey_r,
  input  logic              jockey_l,
  output logic              enable,
  output logic              direct,
  output logic [DUTY_W-1:0] duty,
  output logic              busy,
  output logic              fault
);

  localparam int SW = (RAMP_STEP_CYC > 1) ? $clog2(RAMP_STEP_CYC) : 1;
  localparam int DW = (DEAD_CYC > 1) ? $clog2(DEAD_CYC) : 1;
  localparam int LW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  localparam logic [SW-1:0]     STEP_LAST = SW'(RAMP_STEP_CYC - 1);
  localparam logic [DW-1:0]     DEAD_LAST = DW'(DEAD_CYC - 1);
  localparam logic [LW-1:0]     LEG_LAST  = LW'(TIMEOUT_CYC - 1);
  localparam logic [SW-1:0]     STEP_ONE  = SW'(1);
  localparam logic [DW-1:0]     DEAD_ONE  = DW'(1);
  localparam logic [LW-1:0]     LEG_ONE   = LW'(1);
  localparam logic [DUTY_W-1:0] DUTY_TOP  = DUTY_W'(DUTY_MAX);
  localparam logic [DUTY_W-1:0] DUTY_ONE  = DUTY_W'(1);

  logic [2:0] sync_q;
  logic       cat_s, jr_s, jl_s;

  in_sync #(.W(3)) u_in_sync (
    .clk   (sclk),
    .rst_n (s_rst_n),
    .d     ({catcher, jockey_r, jockey_l}),
    .q     (sync_q)
  );

  assign cat_s = sync_q[2];
  assign jr_s  = sync_q[1];
  assign jl_s  = sync_q[0];

  state_t            state, state_n;
  logic              leg, leg_n;
  logic              abort_q, abort_n;
  logic [DUTY_W-1:0] duty_n;
  logic              direct_n;
  logic [SW-1:0]     step_cnt, step_n;
  logic [DW-1:0]     dead_cnt, dead_n;
  logic [LW-1:0]     leg_cnt, leg_cnt_n;

  logic both_lim, act_lim, step_done, dead_done, leg_done;

  assign both_lim  = jr_s & jl_s;
  assign act_lim   = (leg == OUT) ? jr_s : jl_s;
  assign step_done = (step_cnt == STEP_LAST);
  assign dead_done = (dead_cnt == DEAD_LAST);
  assign leg_done  = (leg_cnt == LEG_LAST);

  always_comb begin
    state_n  = state;
    leg_n    = leg;
    abort_n  = abort_q;
    duty_n   = duty;
    direct_n = direct;

    case (state)
      IDLE: begin
        if (start) begin
          if (both_lim) begin
            state_n = FAULT;
          end else begin
            // Already parked at the right end: go straight to the return leg.
            state_n  = RAMP_UP;
            duty_n   = DUTY_ONE;
            leg_n    = jr_s ? RET : OUT;
            direct_n = jr_s ? RET : OUT;
          end
        end
      end

      RAMP_UP, RUN, RAMP_DOWN: begin
        if (start) abort_n = 1'b1;
        if (both_lim || leg_done) begin
          state_n = FAULT;
          duty_n  = '0;
        end else if (act_lim) begin
          state_n = DEAD;
          duty_n  = '0;
        end else if ((state != RAMP_DOWN) && (start || ((leg == OUT) && cat_s))) begin
          state_n = RAMP_DOWN;
        end else if (step_done && (state == RAMP_UP)) begin
          duty_n = duty + DUTY_ONE;
          if (duty_n == DUTY_TOP) state_n = RUN;
        end else if (step_done && (state == RAMP_DOWN)) begin
          if (duty == DUTY_ONE) begin
            state_n = DEAD;
            duty_n  = '0;
          end else begin
            duty_n = duty - DUTY_ONE;
          end
        end
      end

      DEAD: begin
        if (both_lim) begin
          state_n = FAULT;
        end else if (dead_done) begin
          if (!abort_q && (leg == OUT)) begin
            state_n  = RAMP_UP;
            leg_n    = RET;
            direct_n = RET;
            duty_n   = DUTY_ONE;
          end else begin
            state_n = IDLE;
            abort_n = 1'b0;
            leg_n   = OUT;
          end
        end
      end

      FAULT: begin
        duty_n = '0;
        if (start && !jr_s && !jl_s) begin
          state_n = IDLE;
          abort_n = 1'b0;
          leg_n   = OUT;
        end
      end

      default: begin
        state_n = IDLE;
        duty_n  = '0;
      end
    endcase

    // Ramp timing restarts whenever duty or state moves so every step is a full period.
    if ((state_n != state) || (duty_n != duty) ||
        !((state_n == RAMP_UP) || (state_n == RAMP_DOWN))) begin
      step_n = '0;
    end else begin
      step_n = step_cnt + STEP_ONE;
    end

    dead_n = ((state == DEAD) && (state_n == DEAD)) ? (dead_cnt + DEAD_ONE) : '0;

    if ((state_n == RAMP_UP) && (state != RAMP_UP)) begin
      leg_cnt_n = '0;
    end else if (is_moving(state_n)) begin
      leg_cnt_n = leg_cnt + LEG_ONE;
    end else begin
      leg_cnt_n = leg_cnt;
    end
  end

  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      state    <= IDLE;
      leg      <= OUT;
      abort_q  <= 1'b0;
      step_cnt <= '0;
      dead_cnt <= '0;
      leg_cnt  <= '0;
      enable   <= 1'b0;
      direct   <= 1'b0;
      duty     <= '0;
      busy     <= 1'b0;
      fault    <= 1'b0;
    end else begin
      state    <= state_n;
      leg      <= leg_n;
      abort_q  <= abort_n;
      step_cnt <= step_n;
      dead_cnt <= dead_n;
      leg_cnt  <= leg_cnt_n;
      enable   <= is_moving(state_n);
      direct   <= direct_n;
      duty     <= duty_n;
      busy     <= (state_n != IDLE) && (state_n != FAULT);
      fault    <= (state_n == FAULT);
    end
  end

endmodule

// File: tb/tb_motion_seq.sv
// tb/tb_motion_seq.sv - self-checking bench for motion_seq with short ramp/dead/timeout periods
module tb_motion_seq;

  logic       sclk = 1'b0;
  logic       s_rst_n;
  logic       start, catcher, jockey_r, jockey_l;
  logic       enable, direct, busy, fault;
  logic [2:0] duty;

  typedef struct packed {
    logic       en;
    logic       dir;
    logic [2:0] duty;
    logic       busy;
    logic       flt;
  } exp_t;

  typedef struct {
    logic st;
    logic cat;
    logic jr;
    logic jl;
    exp_t e;
  } vec_t;

  exp_t sb_q[$];
  vec_t tbl[13];
  int   checks = 0;
  int   errors = 0;
  int   cyc_n  = 0;
  logic cat_v  = 1'b0;
  logic jr_v   = 1'b0;
  logic jl_v   = 1'b0;

  always #5 sclk = ~sclk;

  motion_seq #(
    .RAMP_STEP_CYC (4),
    .DEAD_CYC      (10),
    .TIMEOUT_CYC   (200),
    .DUTY_MAX      (7)
  ) dut (
    .sclk     (sclk),
    .s_rst_n  (s_rst_n),
    .start    (start),
    .catcher  (catcher),
    .jockey_r (jockey_r),
    .jockey_l (jockey_l),
    .enable   (enable),
    .direct   (direct),
    .duty     (duty),
    .busy     (busy),
    .fault    (fault)
  );

  function automatic exp_t mk(input logic en, input logic dir, input logic [2:0] d,
                              input logic b, input logic f);
    exp_t e;
    e.en = en; e.dir = dir; e.duty = d; e.busy = b; e.flt = f;
    return e;
  endfunction

  function automatic vec_t mkv(input logic st, input logic cat, input logic jr,
                               input logic jl, input exp_t e);
    vec_t v;
    v.st = st; v.cat = cat; v.jr = jr; v.jl = jl; v.e = e;
    return v;
  endfunction

  task automatic cmp(input exp_t e, input string nm);
    exp_t got;
    got = {enable, direct, duty, busy, fault};
    checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL %s cyc=%0d got en=%b dir=%b duty=%0d busy=%b fault=%b want en=%b dir=%b duty=%0d busy=%b fault=%b",
               nm, cyc_n, got.en, got.dir, got.duty, got.busy, got.flt,
               e.en, e.dir, e.duty, e.busy, e.flt);
    end
  endtask

  // Drive one cycle of stimulus, queue its expected registered response, then check it.
  task automatic tick(input logic st, input exp_t e, input string nm);
    exp_t want;
    @(negedge sclk);
    start    = st;
    catcher  = cat_v;
    jockey_r = jr_v;
    jockey_l = jl_v;
    sb_q.push_back(e);
    @(posedge sclk);
    #1;
    start = 1'b0;
    cyc_n++;
    want = sb_q.pop_front();
    cmp(want, nm);
  endtask

  task automatic ticks(input int n, input exp_t e, input string nm);
    for (int i = 0; i < n; i++) tick(1'b0, e, nm);
  endtask

  task automatic ramp_up_seq(input logic st_first, input logic dir, input string nm);
    for (int d = 1; d <= 6; d++)
      for (int k = 0; k < 4; k++)
        tick((d == 1 && k == 0) ? st_first : 1'b0, mk(1'b1, dir, 3'(d), 1'b1, 1'b0), nm);
  endtask

  task automatic ramp_down_seq(input int from, input logic dir, input string nm);
    for (int d = from; d >= 1; d--)
      for (int k = 0; k < 4; k++)
        tick(1'b0, mk(1'b1, dir, 3'(d), 1'b1, 1'b0), nm);
  endtask

  // Return leg in RUN: left limit stops it three cycles later, dead time, then idle.
  task automatic ret_stop(input string nm);
    jl_v = 1'b1;
    ticks(2, mk(1'b1, 1'b0, 3'd7, 1'b1, 1'b0), {nm, "_latency"});
    tick(1'b0, mk(1'b0, 1'b0, 3'd0, 1'b1, 1'b0), {nm, "_stop"});
    jl_v = 1'b0;
    ticks(9, mk(1'b0, 1'b0, 3'd0, 1'b1, 1'b0), {nm, "_dead"});
    ticks(4, mk(1'b0, 1'b0, 3'd0, 1'b0, 1'b0), {nm, "_idle"});
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired cyc=%0d", cyc_n);
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t idle0, flt0;
    idle0 = mk(1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    flt0  = mk(1'b0, 1'b0, 3'd0, 1'b0, 1'b1);

    tbl[0]  = mkv(1'b0, 1'b0, 1'b0, 1'b0, idle0);
    tbl[1]  = mkv(1'b0, 1'b1, 1'b0, 1'b0, idle0);
    tbl[2]  = mkv(1'b0, 1'b0, 1'b1, 1'b1, idle0);
    tbl[3]  = mkv(1'b0, 1'b0, 1'b1, 1'b1, idle0);
    tbl[4]  = mkv(1'b0, 1'b0, 1'b1, 1'b1, idle0);
    tbl[5]  = mkv(1'b1, 1'b0, 1'b1, 1'b1, flt0);
    tbl[6]  = mkv(1'b0, 1'b0, 1'b1, 1'b1, flt0);
    tbl[7]  = mkv(1'b1, 1'b0, 1'b1, 1'b1, flt0);
    tbl[8]  = mkv(1'b0, 1'b0, 1'b0, 1'b0, flt0);
    tbl[9]  = mkv(1'b0, 1'b0, 1'b0, 1'b0, flt0);
    tbl[10] = mkv(1'b0, 1'b0, 1'b0, 1'b0, flt0);
    tbl[11] = mkv(1'b1, 1'b0, 1'b0, 1'b0, idle0);
    tbl[12] = mkv(1'b0, 1'b0, 1'b0, 1'b0, idle0);

    s_rst_n  = 1'b0;
    start    = 1'b0;
    catcher  = 1'b0;
    jockey_r = 1'b0;
    jockey_l = 1'b0;
    #12;
    cmp(idle0, "reset_state");
    @(negedge sclk);
    s_rst_n = 1'b1;

    for (int i = 0; i < 13; i++) begin
      cat_v = tbl[i].cat;
      jr_v  = tbl[i].jr;
      jl_v  = tbl[i].jl;
      tick(tbl[i].st, tbl[i].e, $sformatf("tbl%0d", i));
    end
    cat_v = 1'b0; jr_v = 1'b0; jl_v = 1'b0;
    ticks(3, idle0, "pre_idle");

    // Full shuttle: right limit at leg cycle 60, left limit on the return leg.
    ramp_up_seq(1'b1, 1'b1, "shut_out_ramp");
    ticks(35, mk(1'b1, 1'b1, 3'd7, 1'b1, 1'b0), "shut_out_run");
    jr_v = 1'b1;
    ticks(2, mk(1'b1, 1'b1, 3'd7, 1'b1, 1'b0), "shut_jr_latency");
    tick(1'b0, mk(1'b0, 1'b1, 3'd0, 1'b1, 1'b0), "shut_jr_stop");
    jr_v = 1'b0;
    ticks(9, mk(1'b0, 1'b1, 3'd0, 1'b1, 1'b0), "shut_dead");
    ramp_up_seq(1'b0, 1'b0, "shut_ret_ramp");
    ticks(4, mk(1'b1, 1'b0, 3'd7, 1'b1, 1'b0), "shut_ret_run");
    ret_stop("shut_ret");

    // Catcher on the outbound leg ramps down; catcher on the return leg is ignored.
    ramp_up_seq(1'b1, 1'b1, "cat_ramp");
    ticks(5, mk(1'b1, 1'b1, 3'd7, 1'b1, 1'b0), "cat_run");
    cat_v = 1'b1;
    tick(1'b0, mk(1'b1, 1'b1, 3'd7, 1'b1, 1'b0), "cat_pulse");
    cat_v = 1'b0;
    tick(1'b0, mk(1'b1, 1'b1, 3'd7, 1'b1, 1'b0), "cat_latency");
    ramp_down_seq(7, 1'b1, "cat_ramp_down");
    ticks(10, mk(1'b0, 1'b1, 3'd0, 1'b1, 1'b0), "cat_dead");
    ramp_up_seq(1'b0, 1'b0, "cat_ret_ramp");
    ticks(2, mk(1'b1, 1'b0, 3'd7, 1'b1, 1'b0), "cat_ret_run");
    cat_v = 1'b1;
    tick(1'b0, mk(1'b1, 1'b0, 3'd7, 1'b1, 1'b0), "cat_ret_pulse");
    cat_v = 1'b0;
    ticks(3, mk(1'b1, 1'b0, 3'd7, 1'b1, 1'b0), "cat_ret_ignored");
    ret_stop("cat_ret");

    // Abort at duty 3 on the outbound ramp: ramp down, dead time, idle, no return leg.
    tick(1'b1, mk(1'b1, 1'b1, 3'd1, 1'b1, 1'b0), "abort_go");
    ticks(3, mk(1'b1, 1'b1, 3'd1, 1'b1, 1'b0), "abort_d1");
    ticks(4, mk(1'b1, 1'b1, 3'd2, 1'b1, 1'b0), "abort_d2");
    tick(1'b0, mk(1'b1, 1'b1, 3'd3, 1'b1, 1'b0), "abort_d3");
    tick(1'b1, mk(1'b1, 1'b1, 3'd3, 1'b1, 1'b0), "abort_start");
    ticks(3, mk(1'b1, 1'b1, 3'd3, 1'b1, 1'b0), "abort_hold3");
    ramp_down_seq(2, 1'b1, "abort_ramp_down");
    ticks(10, mk(1'b0, 1'b1, 3'd0, 1'b1, 1'b0), "abort_dead");
    ticks(12, mk(1'b0, 1'b1, 3'd0, 1'b0, 1'b0), "abort_no_return");

    // Timeout: 200 powered cycles, then fault; exit only with both limits low.
    ramp_up_seq(1'b1, 1'b1, "to_ramp");
    ticks(176, mk(1'b1, 1'b1, 3'd7, 1'b1, 1'b0), "to_run");
    tick(1'b0, mk(1'b0, 1'b1, 3'd0, 1'b0, 1'b1), "to_fault");
    ticks(3, mk(1'b0, 1'b1, 3'd0, 1'b0, 1'b1), "to_fault_hold");
    jr_v = 1'b1;
    ticks(3, mk(1'b0, 1'b1, 3'd0, 1'b0, 1'b1), "to_fault_lim");
    tick(1'b1, mk(1'b0, 1'b1, 3'd0, 1'b0, 1'b1), "to_start_lim_high");
    jr_v = 1'b0;
    ticks(3, mk(1'b0, 1'b1, 3'd0, 1'b0, 1'b1), "to_fault_clear");
    tick(1'b1, mk(1'b0, 1'b1, 3'd0, 1'b0, 1'b0), "to_fault_exit");
    ticks(2, mk(1'b0, 1'b1, 3'd0, 1'b0, 1'b0), "to_idle");

    // Start while parked on the right limit: first leg is the return leg.
    jr_v = 1'b1;
    ticks(3, mk(1'b0, 1'b1, 3'd0, 1'b0, 1'b0), "jr_idle");
    tick(1'b1, mk(1'b1, 1'b0, 3'd1, 1'b1, 1'b0), "jr_start_dir");
    jr_v = 1'b0;
    ticks(3, mk(1'b1, 1'b0, 3'd1, 1'b1, 1'b0), "jr_ret_d1");
    jl_v = 1'b1;
    ticks(2, mk(1'b1, 1'b0, 3'd2, 1'b1, 1'b0), "jr_ret_d2");
    tick(1'b0, mk(1'b0, 1'b0, 3'd0, 1'b1, 1'b0), "jr_jl_stop");
    jl_v = 1'b0;
    ticks(9, mk(1'b0, 1'b0, 3'd0, 1'b1, 1'b0), "jr_dead");
    ticks(3, mk(1'b0, 1'b0, 3'd0, 1'b0, 1'b0), "jr_idle_end");

    // Both limits high while moving outbound: fault wins over the hard stop.
    tick(1'b1, mk(1'b1, 1'b1, 3'd1, 1'b1, 1'b0), "both_go");
    ticks(3, mk(1'b1, 1'b1, 3'd1, 1'b1, 1'b0), "both_d1");
    ticks(4, mk(1'b1, 1'b1, 3'd2, 1'b1, 1'b0), "both_d2");
    tick(1'b0, mk(1'b1, 1'b1, 3'd3, 1'b1, 1'b0), "both_d3");
    jr_v = 1'b1; jl_v = 1'b1;
    ticks(2, mk(1'b1, 1'b1, 3'd3, 1'b1, 1'b0), "both_latency");
    tick(1'b0, mk(1'b0, 1'b1, 3'd0, 1'b0, 1'b1), "both_fault");
    jr_v = 1'b0; jl_v = 1'b0;
    ticks(3, mk(1'b0, 1'b1, 3'd0, 1'b0, 1'b1), "both_fault_hold");
    tick(1'b1, mk(1'b0, 1'b1, 3'd0, 1'b0, 1'b0), "both_exit");
    ticks(2, mk(1'b0, 1'b1, 3'd0, 1'b0, 1'b0), "both_idle");

    // Asynchronous reset in the middle of RUN.
    ramp_up_seq(1'b1, 1'b1, "rst_ramp");
    ticks(6, mk(1'b1, 1'b1, 3'd7, 1'b1, 1'b0), "rst_run");
    @(negedge sclk);
    #2;
    s_rst_n = 1'b0;
    #1;
    cmp(idle0, "async_reset");
    @(posedge sclk);
    #1;
    cmp(idle0, "reset_hold");
    @(negedge sclk);
    s_rst_n = 1'b1;
    ticks(3, idle0, "post_reset_idle");
    ramp_up_seq(1'b1, 1'b1, "post_reset_ramp");
    ticks(2, mk(1'b1, 1'b1, 3'd7, 1'b1, 1'b0), "post_reset_run");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
